// File: rtl/gmii_rx_nibble_align_if.sv
// GMII receive bus into the aligner and the aligned byte stream out of it.
// The master modport drives the GMII side; the aligner is the slave.
interface gmii_rx_nibble_align_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] m_rxd;
  logic       m_rx_dv;
  logic       m_rx_er;
  logic       m_rx_valid;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  m_rxd, m_rx_dv, m_rx_er, m_rx_valid
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output m_rxd, m_rx_dv, m_rx_er, m_rx_valid
  );
endinterface

// File: rtl/gmii_rx_nibble_align.sv
// GMII rx aligner: 1G byte pass-through or 10/100 nibble packing on the SFD.
// Define RGMII_INBAND_STATUS_EN to build the in-band link status decoder.
module gmii_rx_nibble_align #(
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mii_select,
  gmii_rx_nibble_align_if.slave        bus,
  output logic                         align_error,
  output logic                         link_up,
  output logic [1:0]                   link_speed,
  output logic                         full_duplex,
  output logic                         status_valid
);

  if (STABLE_COUNT < 1 || STABLE_COUNT > 255) begin : g_cfg_err
    $error("STABLE_COUNT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DISCARD
  } state_t;

  state_t     state, state_d;
  logic       mode_mii, mode_d;
  logic       armed, armed_d;
  logic       phase, phase_d;
  logic [3:0] low_nib, low_d;
  logic       low_er, low_er_d;
  logic       end_pend, end_d;
  logic [7:0] rxd_d;
  logic       dv_d, er_d, vld_d, aerr_d;

  logic [3:0] nib;
  logic       dv, er;

  assign nib = bus.gmii_rxd[3:0];
  assign dv  = bus.gmii_rx_dv;
  assign er  = bus.gmii_rx_er;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      mode_mii       <= 1'b0;
      armed          <= 1'b0;
      phase          <= 1'b0;
      low_nib        <= '0;
      low_er         <= 1'b0;
      end_pend       <= 1'b0;
      bus.m_rxd      <= '0;
      bus.m_rx_dv    <= 1'b0;
      bus.m_rx_er    <= 1'b0;
      bus.m_rx_valid <= 1'b0;
      align_error    <= 1'b0;
    end else begin
      state          <= state_d;
      mode_mii       <= mode_d;
      armed          <= armed_d;
      phase          <= phase_d;
      low_nib        <= low_d;
      low_er         <= low_er_d;
      end_pend       <= end_d;
      bus.m_rxd      <= rxd_d;
      bus.m_rx_dv    <= dv_d;
      bus.m_rx_er    <= er_d;
      bus.m_rx_valid <= vld_d;
      align_error    <= aerr_d;
    end
  end

  always_comb begin
    state_d  = state;
    mode_d   = mode_mii;
    armed_d  = armed;
    phase_d  = phase;
    low_d    = low_nib;
    low_er_d = low_er;
    end_d    = 1'b0;
    rxd_d    = '0;
    dv_d     = 1'b0;
    er_d     = 1'b0;
    vld_d    = 1'b0;
    aerr_d   = 1'b0;

    // End marker deferred behind a flushed half byte
    if (end_pend) begin
      vld_d = 1'b1;
    end

    if (!mode_mii) begin
      if (armed) begin
        rxd_d = bus.gmii_rxd;
        dv_d  = dv;
        er_d  = er;
        vld_d = 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!dv) begin
            armed_d = 1'b1;
            mode_d  = mii_select;
          end else if (armed) begin
            state_d = DATA;
          end
        end
        default: begin
          if (!dv) begin
            state_d = IDLE;
          end
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (!dv) begin
            armed_d = 1'b1;
            mode_d  = mii_select;
          end else if (armed) begin
            if (nib == 4'h5) begin
              state_d = PREAMBLE;
              phase_d = 1'b1;
            end else begin
              state_d = DISCARD;
              aerr_d  = 1'b1;
            end
          end
        end
        PREAMBLE: begin
          if (!dv) begin
            vld_d   = 1'b1;
            phase_d = 1'b0;
            state_d = IDLE;
          end else if (nib == 4'h5) begin
            if (phase) begin
              vld_d = 1'b1;
              rxd_d = 8'h55;
              dv_d  = 1'b1;
            end
            phase_d = ~phase;
          end else if (nib == 4'hD) begin
            // Either phase accepted: odd preamble counts still lock
            vld_d   = 1'b1;
            rxd_d   = 8'hD5;
            dv_d    = 1'b1;
            phase_d = 1'b0;
            state_d = DATA;
          end else begin
            state_d = DISCARD;
            aerr_d  = 1'b1;
          end
        end
        DATA: begin
          if (!dv) begin
            vld_d = 1'b1;
            if (phase) begin
              rxd_d = {4'h0, low_nib};
              dv_d  = 1'b1;
              er_d  = 1'b1;
              end_d = 1'b1;
            end
            phase_d = 1'b0;
            state_d = IDLE;
          end else if (!phase) begin
            low_d    = nib;
            low_er_d = er;
            phase_d  = 1'b1;
          end else begin
            vld_d   = 1'b1;
            rxd_d   = {nib, low_nib};
            dv_d    = 1'b1;
            er_d    = er | low_er;
            phase_d = 1'b0;
          end
        end
        DISCARD: begin
          if (!dv) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

`ifdef RGMII_INBAND_STATUS_EN
  logic [3:0] smp_q;
  logic [7:0] stab_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q        <= '0;
      stab_cnt     <= '0;
      link_up      <= 1'b0;
      link_speed   <= 2'b00;
      full_duplex  <= 1'b0;
      status_valid <= 1'b0;
    end else begin
      if (dv || er) begin
        stab_cnt <= '0;
      end else begin
        smp_q <= nib;
        if (nib == smp_q) begin
          if (stab_cnt != 8'hFF) begin
            stab_cnt <= stab_cnt + 8'd1;
          end
        end else begin
          stab_cnt <= 8'd1;
        end
      end
      // smp_q still holds the sample that completed the run
      if (stab_cnt == 8'(STABLE_COUNT)) begin
        link_up      <= smp_q[0];
        link_speed   <= smp_q[2:1];
        full_duplex  <= smp_q[3];
        status_valid <= 1'b1;
      end
    end
  end
`else
  assign link_up      = 1'b0;
  assign link_speed   = 2'b00;
  assign full_duplex  = 1'b0;
  assign status_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_rx_nibble_align.sv
// Directed bench for gmii_rx_nibble_align: 1G, nibble framing,
// preamble error recovery, mid-frame reset and in-band status.
module tb_gmii_rx_nibble_align;

`ifdef RGMII_INBAND_STATUS_EN
  localparam bit INB = 1'b1;
`else
  localparam bit INB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mii_select;
  logic       align_error;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;
  logic       status_valid;

  gmii_rx_nibble_align_if bus();

  gmii_rx_nibble_align #(.STABLE_COUNT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mii_select   (mii_select),
    .bus          (bus),
    .align_error  (align_error),
    .link_up      (link_up),
    .link_speed   (link_speed),
    .full_duplex  (full_duplex),
    .status_valid (status_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cap_en = 1'b0;
  logic [9:0] capq[$];
  logic [9:0] expq[$];
  int cycq[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (cap_en && bus.m_rx_valid) begin
      capq.push_back({bus.m_rx_dv, bus.m_rx_er,
                      bus.m_rx_dv ? bus.m_rxd : 8'h00});
      cycq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] n);
    bus.gmii_rx_dv = 1'b1;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = {4'h0, n};
    tick();
  endtask

  task automatic idle(input int n);
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (n) tick();
  endtask

  task automatic preamble(input int n5);
    repeat (n5) nib(4'h5);
    nib(4'hD);
  endtask

  task automatic exp_b(input logic dv, input logic er, input logic [7:0] b);
    expq.push_back({dv, er, b});
  endtask

  task automatic exp_pre();
    repeat (7) exp_b(1'b1, 1'b0, 8'h55);
    exp_b(1'b1, 1'b0, 8'hD5);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, 32'(capq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < capq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(capq[i]), 32'(expq[i]));
    capq.delete();
    expq.delete();
    cycq.delete();
  endtask

  task automatic frame_even();
    preamble(15);
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    idle(3);
    exp_pre();
    exp_b(1'b1, 1'b0, 8'h21);
    exp_b(1'b1, 1'b0, 8'h43);
    exp_b(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] g1[12];

  initial begin
    rst = 1'b1;
    mii_select = 1'b0;
    bus.gmii_rxd = 8'h00;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(bus.m_rx_valid), 0);
    chk("rst_rxd", 32'(bus.m_rxd), 0);
    chk("rst_dv", 32'(bus.m_rx_dv), 0);
    chk("rst_aerr", 32'(align_error), 0);
    chk("rst_link", 32'(link_up), 0);
    chk("rst_speed", 32'(link_speed), 0);
    chk("rst_sval", 32'(status_valid), 0);
    rst = 1'b0;
    tick();

    // In-band status: a 3-long run must not qualify, a 4-long one must
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd = 8'h0D;
    repeat (3) tick();
    bus.gmii_rxd = 8'h00;
    tick();
    bus.gmii_rx_er = 1'b1;
    tick(); tick();
    chk("st_short_link", 32'(link_up), 0);
    chk("st_short_sval", 32'(status_valid), 0);
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd = 8'h0D;
    repeat (4) tick();
    bus.gmii_rx_er = 1'b1;
    tick();
    chk("st_link", 32'(link_up), INB ? 1 : 0);
    chk("st_speed", 32'(link_speed), INB ? 2 : 0);
    chk("st_fdx", 32'(full_duplex), INB ? 1 : 0);
    chk("st_sval", 32'(status_valid), INB ? 1 : 0);

    // 1G pass-through
    mii_select = 1'b0;
    idle(2);
    for (int i = 0; i < 7; i++) g1[i] = 8'h55;
    g1[7] = 8'hD5;
    for (int i = 0; i < 4; i++) g1[8+i] = 8'(i + 1);
    for (int i = 0; i < 12; i++) begin
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rxd = g1[i];
      tick();
      chk($sformatf("g1_rxd%0d", i), 32'(bus.m_rxd), 32'(g1[i]));
      chk($sformatf("g1_dv%0d", i), 32'(bus.m_rx_dv), 1);
      chk($sformatf("g1_vld%0d", i), 32'(bus.m_rx_valid), 1);
    end
    idle(1);
    chk("g1_end_dv", 32'(bus.m_rx_dv), 0);
    chk("g1_end_vld", 32'(bus.m_rx_valid), 1);

    // Nibble mode, even data nibble count
    mii_select = 1'b1;
    idle(2);
    capq.delete();
    cycq.delete();
    cap_en = 1'b1;
    frame_even();
    cmp_q("even");

    // Odd data nibble count: flushed half byte then end marker
    preamble(14);
    nib(4'h1); nib(4'h2); nib(4'h3);
    idle(3);
    exp_pre();
    exp_b(1'b1, 1'b0, 8'h21);
    exp_b(1'b1, 1'b1, 8'h03);
    exp_b(1'b0, 1'b0, 8'h00);
    if (cycq.size() >= 2)
      chk("odd_b2b", 32'(cycq[cycq.size()-1] - cycq[cycq.size()-2]), 1);
    else
      chk("odd_b2b_cnt", 32'(cycq.size()), 2);
    cmp_q("odd");

    // Bad preamble nibble: one-cycle align_error, silence until dv drops
    nib(4'h5); nib(4'h5); nib(4'hA);
    chk("aerr_hi", 32'(align_error), 1);
    capq.delete();
    cycq.delete();
    nib(4'h5);
    chk("aerr_lo", 32'(align_error), 0);
    nib(4'hD); nib(4'h1); nib(4'h2);
    idle(1);
    chk("disc_quiet", 32'(capq.size()), 0);
    idle(1);
    frame_even();
    cmp_q("after_err");

    // Reset mid-DATA clears outputs at once; re-arm needs dv low
    preamble(15);
    nib(4'h1); nib(4'h2);
    chk("pre_rst_vld", 32'(bus.m_rx_valid), 1);
    cap_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_vld", 32'(bus.m_rx_valid), 0);
    chk("async_rxd", 32'(bus.m_rxd), 0);
    chk("async_dv", 32'(bus.m_rx_dv), 0);
    tick();
    rst = 1'b0;
    capq.delete();
    cycq.delete();
    cap_en = 1'b1;
    repeat (6) nib(4'h5);
    nib(4'hD); nib(4'h1); nib(4'h2);
    chk("post_rst_quiet", 32'(capq.size()), 0);
    idle(2);
    chk("post_rst_arm", 32'(capq.size()), 0);
    frame_even();
    cmp_q("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
